// File: rtl/idli_uart_m.sv
`default_nettype none
// =============================================================================
// Module   : idli_uart_m
// Brief    : Full-duplex 8N1 UART; 16-bit core words sent as two frames, low byte first
// Revision : 1.0
// =============================================================================
module idli_uart_m #(
  parameter int CLKS_PER_BIT = 4,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4
) (
  input  logic       i_top_gck,
  input  logic       i_top_rst_n,
  input  logic [1:0] i_uart_ctr,
  input  logic [3:0] i_uart_tx_data,
  input  logic       i_uart_tx_vld,
  output logic       o_uart_tx_acp,
  output logic [3:0] o_uart_rx_data,
  output logic       o_uart_rx_vld,
  input  logic       i_uart_rx_acp,
  output logic       o_uart_rx_ovf,
  output logic       o_uart_rx_ferr,
  input  logic       i_uart_rx,
  output logic       o_uart_tx
);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;
  localparam logic [CW-1:0]  c_bit_last = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  c_bit_mid  = CW'(CLKS_PER_BIT / 2);
  localparam logic [TCW-1:0] c_tx_depth = TCW'(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic w_slice_end;
  assign w_slice_end = (i_uart_ctr == 2'd3);

  // ---------------------------------------------------------------- TX path
  logic [11:0]    r_tx_stage;
  logic [15:0]    r_tx_mem [TX_DEPTH];
  logic [TCW-1:0] r_tx_wr, r_tx_rd;
  logic           r_tx_acp;
  logic           w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [TCW-1:0] w_tx_count_nxt;
  logic [15:0]    w_tx_head;

  tx_state_t      r_tx_state;
  logic [CW-1:0]  r_tx_cnt;
  logic [2:0]     r_tx_bit;
  logic           r_tx_hsel;
  logic [15:0]    r_tx_word;
  logic           r_tx;
  logic           w_tx_bit_end;
  logic [7:0]     w_tx_byte;

  assign w_tx_empty     = (r_tx_wr == r_tx_rd);
  assign w_tx_full      = (r_tx_wr[TAW-1:0] == r_tx_rd[TAW-1:0]) && (r_tx_wr[TAW] != r_tx_rd[TAW]);
  assign w_tx_push      = w_slice_end && i_uart_tx_vld && r_tx_acp && !w_tx_full;
  assign w_tx_head      = r_tx_mem[r_tx_rd[TAW-1:0]];
  assign w_tx_bit_end   = (r_tx_cnt == c_bit_last);
  assign w_tx_byte      = r_tx_hsel ? r_tx_word[15:8] : r_tx_word[7:0];
  // Popping straight out of the last stop bit keeps consecutive words gap-free.
  assign w_tx_pop       = !w_tx_empty && ((r_tx_state == TX_IDLE) ||
                          ((r_tx_state == TX_STOP) && w_tx_bit_end && r_tx_hsel));
  assign w_tx_count_nxt = (r_tx_wr - r_tx_rd) + {{TAW{1'b0}}, w_tx_push} - {{TAW{1'b0}}, w_tx_pop};

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_tx_stage <= '0;
    end else begin
      case (i_uart_ctr)
        2'd0:    r_tx_stage[3:0]  <= i_uart_tx_data;
        2'd1:    r_tx_stage[7:4]  <= i_uart_tx_data;
        2'd2:    r_tx_stage[11:8] <= i_uart_tx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_top_gck) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[TAW-1:0]] <= {i_uart_tx_data, r_tx_stage};
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_acp <= 1'b1;
    end else begin
      if (w_tx_push)   r_tx_wr  <= r_tx_wr + TCW'(1);
      if (w_tx_pop)    r_tx_rd  <= r_tx_rd + TCW'(1);
      if (w_slice_end) r_tx_acp <= (w_tx_count_nxt < c_tx_depth);
    end
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_hsel  <= 1'b0;
      r_tx_word  <= '0;
      r_tx       <= 1'b1;
    end else begin
      if (r_tx_state != TX_IDLE) r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + CW'(1);
      case (r_tx_state)
        TX_IDLE: if (w_tx_pop) begin
          r_tx_word  <= w_tx_head;
          r_tx_hsel  <= 1'b0;
          r_tx_cnt   <= '0;
          r_tx_state <= TX_START;
          r_tx       <= 1'b0;
        end
        TX_START: if (w_tx_bit_end) begin
          r_tx_bit   <= 3'd0;
          r_tx_state <= TX_DATA;
          r_tx       <= w_tx_byte[0];
        end
        TX_DATA: if (w_tx_bit_end) begin
          if (r_tx_bit == 3'd7) begin
            r_tx_state <= TX_STOP;
            r_tx       <= 1'b1;
          end else begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx       <= w_tx_byte[r_tx_bit + 3'd1];
          end
        end
        TX_STOP: if (w_tx_bit_end) begin
          if (!r_tx_hsel) begin
            r_tx_hsel  <= 1'b1;
            r_tx_state <= TX_START;
            r_tx       <= 1'b0;
          end else if (w_tx_pop) begin
            r_tx_word  <= w_tx_head;
            r_tx_hsel  <= 1'b0;
            r_tx_state <= TX_START;
            r_tx       <= 1'b0;
          end else begin
            r_tx_state <= TX_IDLE;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic           r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t      r_rx_state;
  logic [CW-1:0]  r_rx_cnt;
  logic [2:0]     r_rx_bit;
  logic [7:0]     r_rx_shift, r_rx_lo;
  logic           r_rx_hsel, r_rx_push, r_rx_ferr, r_rx_ovf, r_rx_vld;
  logic [15:0]    r_rx_word;
  logic [15:0]    r_rx_mem [RX_DEPTH];
  logic [RCW-1:0] r_rx_wr, r_rx_rd;
  logic           w_rx_mid, w_rx_end, w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic [RCW-1:0] w_rx_count_nxt;
  logic [15:0]    w_rx_head;

  assign w_rx_mid       = (r_rx_cnt == c_bit_mid);
  assign w_rx_end       = (r_rx_cnt == c_bit_last);
  assign w_rx_empty     = (r_rx_wr == r_rx_rd);
  assign w_rx_full      = (r_rx_wr[RAW-1:0] == r_rx_rd[RAW-1:0]) && (r_rx_wr[RAW] != r_rx_rd[RAW]);
  assign w_rx_push      = r_rx_push && !w_rx_full;
  assign w_rx_pop       = w_slice_end && r_rx_vld && i_uart_rx_acp && !w_rx_empty;
  assign w_rx_count_nxt = (r_rx_wr - r_rx_rd) + {{RAW{1'b0}}, w_rx_push} - {{RAW{1'b0}}, w_rx_pop};
  assign w_rx_head      = r_rx_mem[r_rx_rd[RAW-1:0]];

  // The FSM counts from the first synchronised low cycle, so mid-bit lands at CLKS_PER_BIT/2.
  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_lo    <= '0;
      r_rx_hsel  <= 1'b0;
      r_rx_push  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_word  <= '0;
    end else begin
      r_rx_s1   <= i_uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_rx_push <= 1'b0;
      r_rx_ferr <= 1'b0;
      if (r_rx_state != RX_IDLE) r_rx_cnt <= w_rx_end ? '0 : r_rx_cnt + CW'(1);
      case (r_rx_state)
        RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
          r_rx_cnt   <= CW'(1);
          r_rx_state <= RX_START;
        end
        RX_START: begin
          if (w_rx_mid && r_rx_s2) begin
            r_rx_state <= RX_IDLE;
          end else if (w_rx_end) begin
            r_rx_bit   <= 3'd0;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (w_rx_mid) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          if (w_rx_end) begin
            r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end
        end
        RX_STOP: if (w_rx_mid) begin
          r_rx_state <= RX_IDLE;
          if (!r_rx_s2) begin
            r_rx_ferr <= 1'b1;
            r_rx_hsel <= 1'b0;
          end else if (!r_rx_hsel) begin
            r_rx_lo   <= r_rx_shift;
            r_rx_hsel <= 1'b1;
          end else begin
            r_rx_hsel <= 1'b0;
            r_rx_push <= 1'b1;
            r_rx_word <= {r_rx_shift, r_rx_lo};
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_top_gck) begin
    if (w_rx_push) r_rx_mem[r_rx_wr[RAW-1:0]] <= r_rx_word;
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_vld <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      r_rx_ovf <= r_rx_push && w_rx_full;
      if (w_rx_push)   r_rx_wr  <= r_rx_wr + RCW'(1);
      if (w_rx_pop)    r_rx_rd  <= r_rx_rd + RCW'(1);
      if (w_slice_end) r_rx_vld <= (w_rx_count_nxt != '0);
    end
  end

  always_comb begin
    o_uart_rx_data = 4'd0;
    if (r_rx_vld) begin
      case (i_uart_ctr)
        2'd0:    o_uart_rx_data = w_rx_head[3:0];
        2'd1:    o_uart_rx_data = w_rx_head[7:4];
        2'd2:    o_uart_rx_data = w_rx_head[11:8];
        default: o_uart_rx_data = w_rx_head[15:12];
      endcase
    end
  end

  assign o_uart_tx_acp  = r_tx_acp;
  assign o_uart_tx      = r_tx;
  assign o_uart_rx_vld  = r_rx_vld;
  assign o_uart_rx_ovf  = r_rx_ovf;
  assign o_uart_rx_ferr = r_rx_ferr;

endmodule
`default_nettype wire

// File: tb/tb_idli_uart_m.sv
`default_nettype none
// =============================================================================
// Module   : tb_idli_uart_m
// Brief    : Scoreboard bench for idli_uart_m (serial decoder/encoder reference model)
// Revision : 1.0
// =============================================================================
module tb_idli_uart_m;
  localparam int CPB = 4;
  localparam int TXD = 2;
  localparam int RXD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ctr = 2'd0;
  logic [3:0] tx_data = 4'd0;
  logic       tx_vld = 1'b0;
  logic       tx_acp;
  logic [3:0] rx_data;
  logic       rx_vld;
  logic       rx_acp = 1'b0;
  logic       rx_ovf, rx_ferr;
  logic       rx_line = 1'b1;
  logic       tx_line;

  idli_uart_m #(.CLKS_PER_BIT(CPB), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .i_top_gck(clk), .i_top_rst_n(rst_n), .i_uart_ctr(ctr),
    .i_uart_tx_data(tx_data), .i_uart_tx_vld(tx_vld), .o_uart_tx_acp(tx_acp),
    .o_uart_rx_data(rx_data), .o_uart_rx_vld(rx_vld), .i_uart_rx_acp(rx_acp),
    .o_uart_rx_ovf(rx_ovf), .o_uart_rx_ferr(rx_ferr),
    .i_uart_rx(rx_line), .o_uart_tx(tx_line)
  );

  int tests = 0, fails = 0, cyc = 0;
  logic [15:0] tx_exp[$];
  logic [15:0] rx_exp[$];
  int ovf_seen = 0, ferr_seen = 0;
  int rx_mode = 1;   // 0: never consume, 1: always, 2: random

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    ctr = ctr + 2'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial decoder on o_uart_tx: samples every bit at mid-bit relative to the start edge.
  bit tm_busy = 0, tm_hi = 0;
  int tm_idx = 0, tm_lo_start = 0;
  logic [7:0] tm_byte = 8'd0, tm_lo = 8'd0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      tm_busy = 0; tm_hi = 0;
    end else if (!tm_busy) begin
      if (tx_line == 1'b0) begin
        tm_busy = 1; tm_idx = 0;
        if (tm_hi) chk("tx_byte_gap", cyc - tm_lo_start, 10 * CPB);
        else tm_lo_start = cyc;
      end
    end else begin
      tm_idx++;
      if (tm_idx == CPB / 2) chk("tx_start_bit", {31'd0, tx_line}, 0);
      else if (tm_idx > CPB / 2 && tm_idx < CPB / 2 + 9 * CPB && (tm_idx - CPB / 2) % CPB == 0)
        tm_byte[(tm_idx - CPB / 2) / CPB - 1] = tx_line;
      else if (tm_idx == CPB / 2 + 9 * CPB) begin
        chk("tx_stop_bit", {31'd0, tx_line}, 1);
        tm_busy = 0;
        if (!tm_hi) begin
          tm_lo = tm_byte; tm_hi = 1;
        end else begin
          tm_hi = 0;
          if (tx_exp.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx_unexpected_word: got 0x%0h, expected no word", {tm_byte, tm_lo});
          end else chk("tx_word", {16'd0, tm_byte, tm_lo}, {16'd0, tx_exp.pop_front()});
        end
      end
    end
  end

  // RX consumer/monitor, plus pulse counters and ctr==3-only change checks.
  bit rm_act = 0, prev_ok = 0;
  logic prev_acp = 1'b0, prev_vld = 1'b0;
  logic [15:0] rm_word = 16'd0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_ok = 0; rm_act = 0; rx_acp = 1'b0;
    end else begin
      if (rx_ovf) ovf_seen++;
      if (rx_ferr) ferr_seen++;
      if (prev_ok && ctr != 2'd0) begin
        chk("tx_acp_stable", {31'd0, tx_acp}, {31'd0, prev_acp});
        chk("rx_vld_stable", {31'd0, rx_vld}, {31'd0, prev_vld});
      end
      prev_ok = 1; prev_acp = tx_acp; prev_vld = rx_vld;
      if (!rx_vld) begin
        chk("rx_data_zero", {28'd0, rx_data}, 0);
        rm_act = 0; rx_acp = 1'b0;
      end else begin
        if (ctr == 2'd0) begin
          rm_act = 1;
          rx_acp = (rx_mode == 1) || (rx_mode == 2 && $urandom_range(0, 3) != 0);
        end
        if (rm_act) rm_word[4 * ctr +: 4] = rx_data;
        if (rm_act && ctr == 2'd3) begin
          rm_act = 0;
          if (rx_acp) begin
            if (rx_exp.size() == 0) begin
              tests++; fails++;
              $display("FAIL rx_unexpected_word: got 0x%0h, expected no word", rm_word);
            end else chk("rx_word", {16'd0, rm_word}, {16'd0, rx_exp.pop_front()});
          end
        end
      end
    end
  end

  task automatic tx_word(input logic [15:0] w, output int t_acc);
    bit done = 0;
    int tries = 0;
    t_acc = -1;
    while (!done && tries < 100) begin
      while (ctr != 2'd0) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        tx_vld = 1'b1;
        tx_data = w[4 * k +: 4];
        if (k == 3 && tx_acp) begin
          done = 1; t_acc = cyc; tx_exp.push_back(w);
        end
        @(negedge clk);
      end
      tries++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL tx_accept_timeout: word 0x%0h not accepted, expected acceptance", w);
    end
  endtask

  task automatic rx_bit(input logic v);
    rx_line = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stopv);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stopv);
    rx_line = 1'b1;
  endtask

  task automatic rx_word(input logic [15:0] w, input int gap);
    rx_byte(w[7:0], 1'b1);
    repeat (gap) @(negedge clk);
    rx_byte(w[15:8], 1'b1);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0) && n < max) begin
      @(negedge clk); n++;
    end
    if (tx_exp.size() != 0 || rx_exp.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d tx / %0d rx words outstanding, expected 0", tx_exp.size(), rx_exp.size());
      tx_exp.delete(); rx_exp.delete();
    end
  endtask

  initial begin
    #200000;
    tests++; fails++;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    int t[6];
    int t_dummy, base, lows;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx_line}, 1);
    chk("rst_tx_acp", {31'd0, tx_acp}, 1);
    chk("rst_rx_vld", {31'd0, rx_vld}, 0);
    chk("rst_rx_data", {28'd0, rx_data}, 0);
    chk("rst_rx_ovf", {31'd0, rx_ovf}, 0);
    chk("rst_rx_ferr", {31'd0, rx_ferr}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single word 0xA55A: start bit right after acceptance, 80 cycles total.
    tx_word(16'hA55A, t_dummy);
    tx_vld = 1'b0;
    chk("tx_idle_at_accept", {31'd0, tx_line}, 1);
    @(negedge clk);
    chk("tx_start_latency", {31'd0, tx_line}, 0);
    repeat (79) @(negedge clk);
    chk("tx_last_stop", {31'd0, tx_line}, 1);
    @(negedge clk);
    chk("tx_idle_after_80", {31'd0, tx_line}, 1);
    wait_drain(50);
    repeat (8) @(negedge clk);

    // Streaming producer into a 2-deep FIFO.
    for (int i = 0; i < 6; i++) tx_word(16'($urandom), t[i]);
    tx_vld = 1'b0;
    chk("tx_stream_acc1", t[1] - t[0], 4);
    chk("tx_stream_acc2", t[2] - t[0], 8);
    chk("tx_stream_acc3_after_pop", t[3] - t[0], 88);
    wait_drain(1000);

    // RX directed word.
    rx_exp.push_back(16'h1234);
    rx_word(16'h1234, 2);
    wait_drain(100);

    // RX overflow with no consumer.
    rx_mode = 0;
    base = ovf_seen;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (i < RXD) rx_exp.push_back(w);
      rx_word(w, 1);
    end
    repeat (20) @(negedge clk);
    chk("rx_ovf_count", ovf_seen - base, 1);
    chk("rx_vld_full", {31'd0, rx_vld}, 1);
    rx_mode = 1;
    wait_drain(100);
    repeat (12) @(negedge clk);
    chk("rx_vld_drained", {31'd0, rx_vld}, 0);

    // Glitch, then framing error resets the byte pairing.
    base = ferr_seen;
    rx_line = 1'b0; @(negedge clk); rx_line = 1'b1;
    repeat (16) @(negedge clk);
    chk("rx_glitch_no_vld", {31'd0, rx_vld}, 0);
    chk("rx_glitch_no_ferr", ferr_seen - base, 0);
    rx_byte(8'h11, 1'b1);
    rx_byte(8'hAA, 1'b0);
    repeat (10) @(negedge clk);
    chk("rx_ferr_count", ferr_seen - base, 1);
    rx_exp.push_back(16'h5678);
    rx_word(16'h5678, 1);
    wait_drain(100);

    // Random concurrent traffic with a random consumer.
    rx_mode = 2;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          tx_word(16'($urandom), t_dummy);
          if ($urandom_range(0, 1) == 0) begin
            tx_vld = 1'b0;
            repeat ($urandom_range(1, 12)) @(negedge clk);
          end
        end
        tx_vld = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          logic [15:0] w;
          w = 16'($urandom);
          rx_exp.push_back(w);
          rx_word(w, $urandom_range(0, 5));
        end
      end
    join
    wait_drain(2000);
    rx_mode = 1;
    repeat (12) @(negedge clk);

    // Asynchronous reset in the middle of a frame.
    rx_mode = 0;
    rx_word(16'hBEEF, 1);
    repeat (12) @(negedge clk);
    chk("rx_vld_before_reset", {31'd0, rx_vld}, 1);
    tx_word(16'h1111, t_dummy);
    tx_word(16'h2222, t_dummy);
    tx_vld = 1'b0;
    repeat (30) @(negedge clk);
    chk("tx_busy_before_reset", {31'd0, tx_line}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_tx_async", {31'd0, tx_line}, 1);
    chk("reset_acp_async", {31'd0, tx_acp}, 1);
    chk("reset_rx_vld_async", {31'd0, rx_vld}, 0);
    tx_exp.delete();
    rx_exp.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx_line == 1'b0 || rx_vld == 1'b1) lows++;
    end
    chk("fifos_empty_after_reset", lows, 0);
    rx_mode = 1;
    tx_word(16'hC3E1, t_dummy);
    tx_vld = 1'b0;
    rx_exp.push_back(16'h9ABC);
    rx_word(16'h9ABC, 0);
    wait_drain(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/idli_uart_m.md
# idli_uart_m

Parametrised full-duplex UART peripheral for the idli core. It replaces the fixed TX-only serialiser with configurable bit timing, TX and RX word FIFOs, and a receive path for the currently unused UART RX pin. It sits between the execute unit (4-bit slice interface, aligned to the 2-bit core slice counter) and the top-level UART pins. Each 16-bit core word is carried as two 8N1 frames, low byte first.

## Interface
- CLKS_PER_BIT, default 4: gck cycles per serial bit; legal range is 4 or more.
- TX_DEPTH, default 4: TX FIFO depth in words; must be a power of two, at least 2.
- RX_DEPTH, default 4: RX FIFO depth in words; must be a power of two, at least 2.
- i_top_gck  input  1  core clock.
- i_top_rst_n  input  1  reset; asynchronous, active-low.
- i_uart_ctr  input  2  core slice counter; slice k of a word is transferred when ctr==k.
- i_uart_tx_data  input  4  TX word slice, LSB slice first.
- i_uart_tx_vld  input  1  TX word valid; held high for all four slices of a word.
- o_uart_tx_acp  output  1  TX space available; stable for a whole word.
- o_uart_rx_data  output  4  RX word slice, LSB slice first.
- o_uart_rx_vld  output  1  RX word valid; stable for a whole word.
- i_uart_rx_acp  input  1  RX consume; sampled at ctr==3.
- o_uart_rx_ovf  output  1  one-cycle pulse: received word dropped because the RX FIFO was full.
- o_uart_rx_ferr  output  1  one-cycle pulse: framing error, byte discarded.
- i_uart_rx  input  1  serial in; asynchronous, idle high.
- o_uart_tx  output  1  serial out; idle high.

## Operation
- **TX word input**
  - Slices are assembled into a 16-bit staging register while ctr is 0..2.
  - At the ctr==3 edge, if i_uart_tx_vld and o_uart_tx_acp are both high, the word is pushed to the TX FIFO.
  - o_uart_tx_acp is registered and updated only at the ctr==3 edge: high when the post-edge FIFO count is below TX_DEPTH. A TX pop on the same edge is counted.
- **TX FSM: IDLE, START, DATA, STOP**
  - Half-select hsel: 0 = low byte, 1 = high byte.
  - IDLE with the FIFO non-empty: pop the word, hsel=0, go to START.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: drive 1 for CLKS_PER_BIT cycles. Then, if hsel==0, set hsel=1 and go to START; otherwise go to IDLE.
- **RX input path**
  - i_uart_rx passes through a 2-flop synchroniser.
- **RX FSM: IDLE, START, DATA, STOP**
  - IDLE: a 1-to-0 transition enters START.
  - START: sample at CLKS_PER_BIT/2. If the sample is high, treat it as a glitch and return to IDLE.
  - DATA: sample each bit at mid-bit, 8 bits.
  - STOP: sample at mid-bit, then go to IDLE.
    - Stop bit 0: pulse o_uart_rx_ferr, discard the byte, reset the pair to expect a low byte.
    - Valid stop bit, low byte: hold the byte.
    - Valid stop bit, high byte: push {hi,lo} to the RX FIFO. If the FIFO is full, drop the word and pulse o_uart_rx_ovf.
- **RX word output**
  - o_uart_rx_vld is registered at the ctr==3 edge: high when the post-edge FIFO count is nonzero.
  - o_uart_rx_data = head[4k+3:4k] when ctr==k; it is 0 when o_uart_rx_vld is low.
  - The head is popped at the ctr==3 edge when o_uart_rx_vld and i_uart_rx_acp are both high.
- **FIFO pointers**
  - Pointers are log2(DEPTH) bits plus one wrap bit.
  - Full: addresses equal and wrap bits differ. Empty: pointers equal.
  - Simultaneous push and pop is legal at any count. Pushing to a full FIFO or popping an empty one never corrupts the pointers.
- **Bit timing**
  - Counters are $clog2(CLKS_PER_BIT) bits wide and count 0..CLKS_PER_BIT-1, then wrap.

## Timing
- **Reset values**
  - Outputs: o_uart_tx=1, o_uart_tx_acp=1, o_uart_rx_vld=0, o_uart_rx_data=0, o_uart_rx_ovf=0, o_uart_rx_ferr=0.
  - Both FSMs in IDLE; FIFOs empty; synchroniser flops set to 1.
- **Reset mid-operation**: takes effect immediately and asynchronously.
  - Any frame in flight is abandoned and o_uart_tx returns to 1.
  - FIFO contents are discarded.
- **TX latency**: the word is accepted at ctr==3 edge E. With TX idle, the FSM pops at E+1 and o_uart_tx=0 from E+1.
  - One word occupies o_uart_tx for 20·CLKS_PER_BIT cycles.
  - Back-to-back words have no idle gap.
- **RX latency**: the word is pushed at the edge after the high byte's stop-bit mid-sample. o_uart_rx_vld rises at the next ctr==3 edge.
- o_uart_tx_acp and o_uart_rx_vld never change except at ctr==3 edges or reset.

## Test plan
- Reset, then a TX word 0xA55A with CLKS_PER_BIT=4:
  - Accepted at ctr==3.
  - o_uart_tx shows frames 0x5A then 0xA5, each 0, 8 LSB-first bits, 1, at 4 cycles per bit.
  - Total 80 cycles, then idle high.
- TX_DEPTH=2, producer streaming constantly:
  - o_uart_tx_acp drops after the FIFO fills (in-flight word plus 2 queued) and recovers at the ctr==3 edge after a pop.
  - No word is lost or duplicated.
- Drive frames 0x34 then 0x12 on i_uart_rx:
  - o_uart_rx_vld rises.
  - Slices 4,3,2,1 appear at ctr 0..3.
  - Pop on i_uart_rx_acp=1.
- RX_DEPTH=2, send 3 words without consuming:
  - The third word pulses o_uart_rx_ovf.
  - Draining yields only the first two words.
- A 1-cycle low glitch on i_uart_rx returns the FSM to IDLE with no data. A frame with stop bit 0 pulses o_uart_rx_ferr, and the next good pair 0x78,0x56 yields 0x5678.
- Assert i_top_rst_n low mid-frame:
  - o_uart_tx goes to 1 immediately; both FIFOs are empty.
  - A new word after reset transmits correctly.
